demux_sel_sequencer: RTL

//  Upstream driver for the 1-to-8 demux stage: generates the 3-bit select (a,b,c) and

---
 rtl/demux_sel_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/demux_sel_sequencer.sv
// Select/enable sequencer for the 1-to-8 demux: advances sel on a prescaled tick or button press.
// Optional DEBOUNCE_EN macro inserts a stable-time debouncer on the synchronized button.
module demux_sel_sequencer #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step_btn,
  input  logic [1:0] mode,
  input  logic       blank,
  output logic [2:0] sel,
  output logic       en,
  output logic       wrap
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_TOP = CW'(TICK_DIV - 1);
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("TICK_DIV must be at least 2");
  end
  if (DB_CYCLES == 0) begin : g_bad_db_cycles
    $error("DB_CYCLES must be nonzero");
  end

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          tick, step, advance;
  logic          sync1, sync2, fill1, fill2, prev, lvl;
  logic          dir, dir_nx, wrap_nx, en_nx;
  logic [2:0]    sel_nx;

  // Prescaler: free-runs while run is high, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (run) cnt <= (cnt == TICK_TOP) ? '0 : cnt + CW'(1);
  end

  assign tick = run & (cnt == TICK_TOP);

  // Synchronizer and edge detect; prev is held high until the sync chain holds
  // real samples, so a button held through reset never registers as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      fill1 <= 1'b0;
      fill2 <= 1'b0;
      prev  <= 1'b1;
    end else begin
      sync1 <= step_btn;
      sync2 <= sync1;
      fill1 <= 1'b1;
      fill2 <= fill1;
      prev  <= fill2 ? lvl : 1'b1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DW-1:0] DB_TOP = DW'(DB_CYCLES - 1);

  logic [DW-1:0] db_cnt;
  logic          db;

  // Level follows sync2 only after DB_CYCLES consecutive mismatching cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db     <= 1'b0;
      db_cnt <= '0;
    end else if (sync2 == db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_TOP) begin
      db     <= sync2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

  assign lvl = db;
`else
  assign lvl = sync2;
`endif

  assign step    = lvl & ~prev;
  assign advance = tick | step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 3'd0;
      dir   <= DIR_UP;
      wrap  <= 1'b0;
      en    <= 1'b0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      dir   <= dir_nx;
      wrap  <= wrap_nx;
      en    <= en_nx;
    end
  end

  // Next sel/dir/wrap per mode; hold mode still leaves IDLE on an advance.
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    dir_nx   = dir;
    wrap_nx  = 1'b0;
    en_nx    = (state == ACTIVE) & ~blank;
    if (advance) begin
      state_nx = ACTIVE;
      case (mode)
        2'b00: begin
          sel_nx  = sel + 3'd1;
          dir_nx  = DIR_UP;
          wrap_nx = (sel == 3'd7);
        end
        2'b01: begin
          sel_nx  = sel - 3'd1;
          dir_nx  = DIR_DOWN;
          wrap_nx = (sel == 3'd0);
        end
        2'b10: begin
          if (dir == DIR_UP) begin
            if (sel == 3'd7) begin
              sel_nx  = 3'd6;
              dir_nx  = DIR_DOWN;
              wrap_nx = 1'b1;
            end else begin
              sel_nx = sel + 3'd1;
            end
          end else begin
            if (sel == 3'd0) begin
              sel_nx  = 3'd1;
              dir_nx  = DIR_UP;
              wrap_nx = 1'b1;
            end else begin
              sel_nx = sel - 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
